periph_bus_master: RTL and testbench
====================================

// Module: periph_bus_master
// PURPOSE
//  Bus initiator for the peripheral register bus (we/addr/data/sel out, combinational rdata in) used by gpio and peers.
//  Accepts one command at a time (valid/ready), runs READ, WRITE, SET/CLR/TOGGLE read-modify-write or POLL, returns one response.
//  Sits between a controller (debug bridge, sequencer) and the peripheral address decoder.
// PARAMETERS
//  POLL_TIMEOUT  1024  max bus reads per POLL before error; >=2
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  cmd_valid_i in   1   command valid
//  cmd_ready_o out  1   command accepted when valid&ready
//  cmd_op_i    in   3   0 READ,1 WRITE,2 SET,3 CLR,4 TOGGLE,5 POLL,6-7 illegal
//  cmd_addr_i  in   32  register address
//  cmd_data_i  in   32  write data / RMW mask / POLL mask
//  cmd_cmp_i   in   32  POLL compare value
//  cmd_sel_i   in   4   byte enables for write phase
//  rsp_valid_o out  1   response valid, held until rsp_ready_i
//  rsp_ready_i in   1   response consumed
//  rsp_data_o  out  32  read value (pre-modify for RMW, last sample for POLL; 0 for WRITE/illegal)
//  rsp_err_o   out  1   illegal op or POLL timeout
//  per_we_o    out  1   bus write strobe; write commits at clk edge
//  per_addr_o  out  32  bus address
//  per_data_o  out  32  bus write data
//  per_sel_o   out  4   bus byte enables
//  per_data_i  in   32  bus read data, combinational from per_addr_o same cycle
// BEHAVIOUR
//  States IDLE, RD, WR, RESP. cmd_ready_o = (state==IDLE). All command fields latched on accept.
//  Reset: state IDLE; cmd_ready_o=1; rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0; per_we_o=0, per_addr_o=0, per_data_o=0, per_sel_o=0.
//  Bus outputs zero (we=0, sel=0) in IDLE and RESP; per_addr_o=latched addr in RD/WR.
//  IDLE->RD for READ/SET/CLR/TOGGLE/POLL; IDLE->WR for WRITE; IDLE->RESP, err=1, no bus cycle, for op 6-7.
//  RD: we=0, sel=0; per_data_i sampled into rdata at clk edge.
//    READ -> RESP. SET/CLR/TOGGLE -> WR. POLL: see below.
//  WR: exactly one cycle we=1, sel=latched sel, data = WRITE: cmd_data; SET: rdata|mask; CLR: rdata&~mask; TOGGLE: rdata^mask. -> RESP.
//    sel=0 still issues the strobe (no bytes change).
//  POLL: one read per RD cycle; counter cleared on accept, +1 per read.
//    match ((per_data_i & mask)==(cmp & mask)) -> RESP, err=0; else if count==POLL_TIMEOUT-1 -> RESP, err=1; else stay RD.
//    Exactly POLL_TIMEOUT reads on timeout; counter width $clog2(POLL_TIMEOUT)+1, never wraps.
//  RESP: rsp_valid_o=1, data/err stable until rsp_ready_i; on handshake -> IDLE, rsp_valid_o=0 next cycle.
//  No new command accepted in the rsp_ready cycle (min 1 IDLE cycle between commands).
//  Latency accept-edge to rsp_valid_o: WRITE/READ 2, RMW 3, illegal 1, POLL 1+N reads.
//  rst in any state: next cycle IDLE, all outputs at reset values, in-flight command dropped, no response;
//    a WR-cycle write coinciding with rst may commit.
// TESTING
//  WRITE addr 0x0 data 0x5 sel 0xF -> cycle+1 we=1 addr 0x0 data 0x5; cycle+2 rsp_valid err=0 data 0.
//  SET addr 0x4, reg=0x00F0, mask 0x0003 -> RD then WR data 0x00F3; rsp_data 0x00F0, err 0.
//  CLR mask 0x0F, sel 0x1 on reg 0xFF -> write 0xF0 sel 0x1; TOGGLE 0x1 on 0xF0 -> write 0xF1.
//  POLL (POLL_TIMEOUT=8) mask 0x1 cmp 0x1, pin goes high on 3rd read -> 3 reads, err 0, data bit0=1; never high -> 8 reads, err 1.
//  op 7 -> rsp_valid cycle+1, err 1, per_we_o never high; rsp_ready low 5 cycles -> outputs stable, cmd_ready_o 0.
//  rst asserted during RMW RD cycle -> no WR strobe, no response, cmd_ready_o 1 next cycle.

Source files
------------

// File: rtl/periph_bus_master.sv
// Peripheral register bus initiator: one command at a time, READ/WRITE/RMW/POLL,
// one response per command. All outputs are registered.
module periph_bus_master #(
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic [31:0] cmd_cmp_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        per_we_o,
  output logic [31:0] per_addr_o,
  output logic [31:0] per_data_o,
  output logic [3:0]  per_sel_o,
  input  logic [31:0] per_data_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  localparam logic [2:0] OpRead   = 3'd0;
  localparam logic [2:0] OpWrite  = 3'd1;
  localparam logic [2:0] OpSet    = 3'd2;
  localparam logic [2:0] OpClr    = 3'd3;
  localparam logic [2:0] OpToggle = 3'd4;
  localparam logic [2:0] OpPoll   = 3'd5;

  localparam int CW = $clog2(POLL_TIMEOUT) + 1;
  localparam logic [CW-1:0] CntLast = CW'(POLL_TIMEOUT - 1);

  state_e        state_q;
  logic [2:0]    op_q;
  logic [31:0]   addr_q, data_q, cmp_q, rdata_q;
  logic [3:0]    sel_q;
  logic [CW-1:0] cnt_q;

  logic          rsp_valid_q, rsp_err_q, per_we_q;
  logic [31:0]   rsp_data_q, per_addr_q, per_data_q;
  logic [3:0]    per_sel_q;

  logic          poll_match;
  logic [31:0]   rmw_data;

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign per_we_o    = per_we_q;
  assign per_addr_o  = per_addr_q;
  assign per_data_o  = per_data_q;
  assign per_sel_o   = per_sel_q;

  assign poll_match = ((per_data_i & data_q) == (cmp_q & data_q));

  // Modified value is formed from the live read data so it is ready for the WR cycle
  always_comb begin
    rmw_data = per_data_i;
    case (op_q)
      OpSet:    rmw_data = per_data_i | data_q;
      OpClr:    rmw_data = per_data_i & ~data_q;
      OpToggle: rmw_data = per_data_i ^ data_q;
      default:  rmw_data = per_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cmp_q       <= '0;
      sel_q       <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      per_we_q    <= 1'b0;
      per_addr_q  <= '0;
      per_data_q  <= '0;
      per_sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q   <= cmd_op_i;
            addr_q <= cmd_addr_i;
            data_q <= cmd_data_i;
            cmp_q  <= cmd_cmp_i;
            sel_q  <= cmd_sel_i;
            cnt_q  <= '0;
            case (cmd_op_i)
              OpRead, OpSet, OpClr, OpToggle, OpPoll: begin
                state_q    <= RD;
                per_addr_q <= cmd_addr_i;
              end
              OpWrite: begin
                state_q    <= WR;
                per_we_q   <= 1'b1;
                per_addr_q <= cmd_addr_i;
                per_data_q <= cmd_data_i;
                per_sel_q  <= cmd_sel_i;
              end
              default: begin
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end
        RD: begin
          rdata_q <= per_data_i;
          cnt_q   <= cnt_q + 1'b1;
          if (op_q == OpSet || op_q == OpClr || op_q == OpToggle) begin
            state_q    <= WR;
            per_we_q   <= 1'b1;
            per_data_q <= rmw_data;
            per_sel_q  <= sel_q;
          end else if (op_q != OpPoll || poll_match || cnt_q == CntLast) begin
            state_q     <= RESP;
            per_addr_q  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= per_data_i;
            rsp_err_q   <= (op_q == OpPoll) && !poll_match;
          end
        end
        WR: begin
          state_q     <= RESP;
          per_we_q    <= 1'b0;
          per_addr_q  <= '0;
          per_data_q  <= '0;
          per_sel_q   <= '0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= (op_q == OpWrite) ? 32'h0 : rdata_q;
          rsp_err_q   <= 1'b0;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: a small register-file peripheral, a response
// scoreboard, a vector table and hand-written stall/reset sequences.
module tb_periph_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [2:0]  cmdOp = '0;
  logic [31:0] cmdAddr = '0, cmdData = '0, cmdCmp = '0;
  logic [3:0]  cmdSel = '0;
  logic        rspValid;
  logic        rspReady = 1'b1;
  logic [31:0] rspData;
  logic        rspErr;
  logic        perWe;
  logic [31:0] perAddr, perWdata, perRdata;
  logic [3:0]  perSel;

  periph_bus_master #(.POLL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_op_i(cmdOp),
    .cmd_addr_i(cmdAddr), .cmd_data_i(cmdData), .cmd_cmp_i(cmdCmp), .cmd_sel_i(cmdSel),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_data_o(rspData), .rsp_err_o(rspErr),
    .per_we_o(perWe), .per_addr_o(perAddr), .per_data_o(perWdata), .per_sel_o(perSel),
    .per_data_i(perRdata)
  );

  always #5 clk = ~clk;

  // Peripheral model: 16 words below 0x40, a poll status register at 0x40
  logic [31:0] mem [16];
  int weCount = 0, readCount = 0;
  logic [31:0] lastWrAddr = '0, lastWrData = '0;
  logic [3:0]  lastWrSel = '0;
  int pollAt = 0, readBase = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (perWe) begin
        weCount    <= weCount + 1;
        lastWrAddr <= perAddr;
        lastWrData <= perWdata;
        lastWrSel  <= perSel;
        if (perAddr < 32'h40)
          for (int b = 0; b < 4; b++)
            if (perSel[b]) mem[perAddr[5:2]][8*b +: 8] <= perWdata[8*b +: 8];
      end else if (perAddr == 32'h40) begin
        readCount <= readCount + 1;
      end
    end
  end

  assign perRdata = (perAddr == 32'h40)
                  ? ((pollAt != 0 && (readCount - readBase) >= pollAt - 1) ? 32'h1 : 32'h0)
                  : mem[perAddr[5:2]];

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;
  rsp_t sb [$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr, data, cmp;
    logic [3:0]  sel;
    int          pollAt;
    logic [31:0] expData;
    logic        expErr;
    int          expLat, expWe;
    logic [31:0] expWrData;
    logic [3:0]  expWrSel;
    int          expReads;
  } vec_t;
  vec_t vecs [$];

  int passed = 0, total = 0;

  function automatic vec_t mk(logic [2:0] op, logic [31:0] addr, logic [31:0] data,
                              logic [31:0] cmp, logic [3:0] sel, int pAt,
                              logic [31:0] eData, logic eErr, int eLat, int eWe,
                              logic [31:0] eWrData, logic [3:0] eWrSel, int eReads);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.cmp = cmp; v.sel = sel; v.pollAt = pAt;
    v.expData = eData; v.expErr = eErr; v.expLat = eLat; v.expWe = eWe;
    v.expWrData = eWrData; v.expWrSel = eWrSel; v.expReads = eReads;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Pops the expected response, compares it, then completes the handshake
  task automatic checkOutput();
    rsp_t e;
    check("rsp_valid", {31'b0, rspValid}, 32'h1);
    if (sb.size() == 0) begin
      total++;
      $display("[TB] FAIL scoreboard: response with no expectation, got 0x%08h", rspData);
    end else begin
      e = sb.pop_front();
      check("rsp_data", rspData, e.data);
      check("rsp_err", {31'b0, rspErr}, {31'b0, e.err});
    end
    @(posedge clk); #1;
    check("rsp_valid drop", {31'b0, rspValid}, 32'h0);
    check("cmd_ready after rsp", {31'b0, cmdReady}, 32'h1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int cycles, weBefore, w;
    w = 0;
    while (!cmdReady && w < 50) begin @(posedge clk); #1; w++; end
    check("cmd_ready before cmd", {31'b0, cmdReady}, 32'h1);
    pollAt   = v.pollAt;
    readBase = readCount;
    weBefore = weCount;
    cmdValid = 1'b1; cmdOp = v.op; cmdAddr = v.addr; cmdData = v.data;
    cmdCmp = v.cmp; cmdSel = v.sel;
    sb.push_back('{v.expData, v.expErr});
    @(posedge clk); #1;
    cmdValid = 1'b0;
    cycles = 1;
    while (!rspValid && cycles < 100) begin @(posedge clk); #1; cycles++; end
    check("latency", cycles, v.expLat);
    checkOutput();
    check("write strobes", weCount - weBefore, v.expWe);
    if (v.expWe > 0) begin
      check("write addr", lastWrAddr, v.addr);
      check("write data", lastWrData, v.expWrData);
      check("write sel", {28'b0, lastWrSel}, {28'b0, v.expWrSel});
    end
    if (v.op == 3'd5) check("poll reads", readCount - readBase, v.expReads);
  endtask

  initial begin
    int weBefore;
    //                op    addr    data          cmp  sel  pAt eData         eErr lat we  eWrData       eWrSel reads
    vecs.push_back(mk(3'd1, 32'h00, 32'h5,        0,   4'hF, 0, 32'h0,        0,   2,  1,  32'h5,        4'hF,  0));
    vecs.push_back(mk(3'd0, 32'h00, 32'h0,        0,   4'hF, 0, 32'h5,        0,   2,  0,  32'h0,        4'h0,  0));
    vecs.push_back(mk(3'd1, 32'h04, 32'hF0,       0,   4'hF, 0, 32'h0,        0,   2,  1,  32'hF0,       4'hF,  0));
    vecs.push_back(mk(3'd2, 32'h04, 32'h3,        0,   4'hF, 0, 32'hF0,       0,   3,  1,  32'hF3,       4'hF,  0));
    vecs.push_back(mk(3'd0, 32'h04, 32'h0,        0,   4'hF, 0, 32'hF3,       0,   2,  0,  32'h0,        4'h0,  0));
    vecs.push_back(mk(3'd1, 32'h08, 32'hFF,       0,   4'hF, 0, 32'h0,        0,   2,  1,  32'hFF,       4'hF,  0));
    vecs.push_back(mk(3'd3, 32'h08, 32'h0F,       0,   4'h1, 0, 32'hFF,       0,   3,  1,  32'hF0,       4'h1,  0));
    vecs.push_back(mk(3'd0, 32'h08, 32'h0,        0,   4'hF, 0, 32'hF0,       0,   2,  0,  32'h0,        4'h0,  0));
    vecs.push_back(mk(3'd4, 32'h08, 32'h1,        0,   4'hF, 0, 32'hF0,       0,   3,  1,  32'hF1,       4'hF,  0));
    vecs.push_back(mk(3'd0, 32'h08, 32'h0,        0,   4'hF, 0, 32'hF1,       0,   2,  0,  32'h0,        4'h0,  0));
    vecs.push_back(mk(3'd1, 32'h0C, 32'h12345678, 0,   4'h0, 0, 32'h0,        0,   2,  1,  32'h12345678, 4'h0,  0));
    vecs.push_back(mk(3'd0, 32'h0C, 32'h0,        0,   4'hF, 0, 32'h0,        0,   2,  0,  32'h0,        4'h0,  0));
    vecs.push_back(mk(3'd1, 32'h10, 32'hAABBCCDD, 0,   4'hF, 0, 32'h0,        0,   2,  1,  32'hAABBCCDD, 4'hF,  0));
    vecs.push_back(mk(3'd2, 32'h10, 32'hFFFF0000, 0,   4'h4, 0, 32'hAABBCCDD, 0,   3,  1,  32'hFFFFCCDD, 4'h4,  0));
    vecs.push_back(mk(3'd0, 32'h10, 32'h0,        0,   4'hF, 0, 32'hAAFFCCDD, 0,   2,  0,  32'h0,        4'h0,  0));
    vecs.push_back(mk(3'd5, 32'h40, 32'h1,        1,   4'h0, 3, 32'h1,        0,   4,  0,  32'h0,        4'h0,  3));
    vecs.push_back(mk(3'd5, 32'h40, 32'h1,        1,   4'h0, 0, 32'h0,        1,   9,  0,  32'h0,        4'h0,  8));
    vecs.push_back(mk(3'd5, 32'h40, 32'h1,        1,   4'h0, 1, 32'h1,        0,   2,  0,  32'h0,        4'h0,  1));
    vecs.push_back(mk(3'd6, 32'h00, 32'hFFFF,     0,   4'hF, 0, 32'h0,        1,   1,  0,  32'h0,        4'h0,  0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset cmd_ready", {31'b0, cmdReady}, 32'h1);
    check("reset rsp_valid", {31'b0, rspValid}, 32'h0);
    check("reset rsp_data", rspData, 32'h0);
    check("reset rsp_err", {31'b0, rspErr}, 32'h0);
    check("reset per_we", {31'b0, perWe}, 32'h0);
    check("reset per_addr", perAddr, 32'h0);
    check("reset per_data", perWdata, 32'h0);
    check("reset per_sel", {28'b0, perSel}, 32'h0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Illegal op with the response stalled for five cycles
    weBefore = weCount;
    rspReady = 1'b0;
    cmdValid = 1'b1; cmdOp = 3'd7; cmdAddr = 32'h4; cmdData = 32'h1; cmdSel = 4'hF;
    sb.push_back('{32'h0, 1'b1});
    @(posedge clk); #1;
    cmdValid = 1'b0;
    check("illegal latency 1", {31'b0, rspValid}, 32'h1);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall rsp_valid", {31'b0, rspValid}, 32'h1);
      check("stall rsp_data", rspData, 32'h0);
      check("stall rsp_err", {31'b0, rspErr}, 32'h1);
      check("stall cmd_ready", {31'b0, cmdReady}, 32'h0);
    end
    rspReady = 1'b1;
    checkOutput();
    check("illegal no strobe", weCount - weBefore, 0);

    // Reset lands while a SET is in its read cycle
    weBefore = weCount;
    cmdValid = 1'b1; cmdOp = 3'd2; cmdAddr = 32'h14; cmdData = 32'h1; cmdSel = 4'hF;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    check("rmw in read cycle", perAddr, 32'h14);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst cmd_ready", {31'b0, cmdReady}, 32'h1);
    check("rst per_addr", perAddr, 32'h0);
    repeat (4) begin
      @(posedge clk); #1;
      check("rst no response", {31'b0, rspValid}, 32'h0);
    end
    check("rst no strobe", weCount - weBefore, 0);
    check("scoreboard empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
